// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM state encoding and byte-lane masks.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [XLEN-1:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [XLEN-1:0] HALF_MASK = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // Encodings accepted for each direction; anything else is illegal.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load-side extract/extend (STORE=0) or store-side
// merge of wdata into an existing word (STORE=1). Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit STORE = 1'b0
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] data_c
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;
    logic [XLEN-1:0]   load_c;
    logic [XLEN-1:0]   merge_c;

    assign byte_sh = {offset, 3'b000};
    assign half_sh = {offset[1], 4'b0000};
    assign byte_v  = BYTE_W'(word >> byte_sh);
    assign half_v  = HALF_W'(word >> half_sh);

    // Load extract with sign or zero extension.
    always_comb begin
        load_c = word;
        case (funct3)
            F3_B:    load_c = {{(XLEN-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
            F3_BU:   load_c = {{(XLEN-BYTE_W){1'b0}}, byte_v};
            F3_H:    load_c = {{(XLEN-HALF_W){half_v[HALF_W-1]}}, half_v};
            F3_HU:   load_c = {{(XLEN-HALF_W){1'b0}}, half_v};
            default: load_c = word;
        endcase
    end

    // Store merge: replace only the addressed lane of the old word.
    always_comb begin
        merge_c = wdata;
        case (funct3)
            F3_B:    merge_c = (word & ~(BYTE_MASK << byte_sh)) | ((wdata & BYTE_MASK) << byte_sh);
            F3_H:    merge_c = (word & ~(HALF_MASK << half_sh)) | ((wdata & HALF_MASK) << half_sh);
            default: merge_c = wdata;
        endcase
    end

    assign data_c = STORE ? merge_c : load_c;

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a word-wide memory with no byte enables; sub-word
// stores use read-modify-write. Build option: LSU_ERR_EN enables error checks.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_we,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    lsu_state_e       state_q, state_d;
    logic [DEPTH-1:0] word_addr_q, word_addr_d;
    logic [1:0]       offset_q, offset_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_wd_q, mem_wd_d;

    logic             legal_c;
    logic [2:0]       f3_eff_c;
    logic             is_half_c;
    logic             is_word_c;
    logic [1:0]       offset_eff_c;
    logic             err_c;
    logic [XLEN-1:0]  load_data_c;
    logic [XLEN-1:0]  merge_data_c;

    // Accept-time decode: illegal encodings fall back to word size and the
    // offset is truncated to the access size.
    always_comb begin
        legal_c      = f3_legal(req_we, req_funct3);
        f3_eff_c     = legal_c ? req_funct3 : F3_W;
        is_half_c    = (f3_eff_c[1:0] == 2'b01);
        is_word_c    = (f3_eff_c[1:0] == 2'b10);
        offset_eff_c = is_word_c ? 2'b00 : (is_half_c ? {req_addr[1], 1'b0} : req_addr[1:0]);
    end

`ifdef LSU_ERR_EN
    logic misalign_c;
    logic range_err_c;
    assign misalign_c  = (is_half_c & req_addr[0]) | (is_word_c & (req_addr[1:0] != 2'b00));
    assign range_err_c = (req_addr >> (DEPTH + 2)) != (BASE_ADDR >> (DEPTH + 2));
    assign err_c       = !legal_c | misalign_c | range_err_c;
`else
    // Without checking, upper address bits and the base are don't-cares.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{req_addr[31:DEPTH+2], BASE_ADDR};
    assign err_c          = 1'b0;
`endif

    lsu_lane_align #(.STORE(1'b0)) u_load_align (
        .word   (mem_rd),
        .offset (offset_q),
        .funct3 (funct3_q),
        .wdata  ('0),
        .data_c (load_data_c)
    );

    lsu_lane_align #(.STORE(1'b1)) u_store_align (
        .word   (mem_rd),
        .offset (offset_q),
        .funct3 (funct3_q),
        .wdata  (wdata_q),
        .data_c (merge_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        offset_d    = offset_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_d    = 1'b0;
        mem_wd_d    = mem_wd_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    word_addr_d = req_addr[DEPTH+1:2];
                    offset_d    = offset_eff_c;
                    funct3_d    = f3_eff_c;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (is_word_c) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data_c;
                rsp_err_d   = 1'b0;
            end
            RMW_READ: begin
                state_d  = WRITE;
                mem_we_d = 1'b1;
                mem_wd_d = merge_data_c;
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Async reset also drops mem_we immediately, aborting any pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            offset_q    <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = word_addr_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Requester-side master for the word-wide data memory (synchronous write, combinational read, word-granular WE).
- Takes byte-addressed RISC-V load/store requests from the core over a valid/ready handshake.
- Performs byte/halfword extraction and sign/zero-extension for loads.
- Sub-word stores use read-modify-write, because the memory has no byte enables.
- Returns a result/status over a valid/ready response channel.

Parameters:
- WIDTH, 32, memory data width; byte-lane logic requires exactly 32.
- DEPTH, 8, memory word-address bits; the memory holds 2**DEPTH words.
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0; must be aligned to 4*2**DEPTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request failed; no memory write was performed.
- mem_we  out  1  memory write enable.
- mem_addr  out  DEPTH  memory word address.
- mem_wd  out  WIDTH  memory write data.
- mem_rd  in  WIDTH  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, active-low) values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Reset mid-operation aborts immediately. mem_we drops asynchronously, so no partial write occurs after reset asserts.
  - The in-flight request is lost.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Accept: req_ready=1 only in IDLE. On req_valid&&req_ready, register we, funct3, addr and wdata. Offset = addr[1:0].
- Error check, at accept:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr[31:DEPTH+2] != BASE_ADDR[31:DEPTH+2].
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - On error: go to RESP with err=1. mem_we is never asserted.
- mem_addr = registered addr[DEPTH+1:2] in all non-IDLE states.
- Load path: IDLE -> LOAD -> RESP.
  - In LOAD, mem_rd is sampled and the selected lane is extracted.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Byte lane = offset*8; halfword lane = offset[1]*16.
  - The result appears in rsp_rdata in RESP. Latency: accept at cycle T, rsp_valid at T+2.
- Store path, SW: IDLE -> WRITE -> RESP.
  - mem_we=1 for exactly one cycle, in WRITE, with mem_wd=wdata. rsp_valid at T+2.
- Store path, SB/SH: IDLE -> RMW_READ -> WRITE -> RESP.
  - RMW_READ latches mem_rd with the target lane replaced by wdata[7:0] or wdata[15:0].
  - WRITE writes the merged word. rsp_valid at T+3.
- RESP:
  - rsp_valid=1, held stable until rsp_ready.
  - rsp_valid&&rsp_ready -> IDLE. The next request is accepted no earlier than the following cycle; no back-to-back overlap.
- mem_we is asserted only in WRITE, for exactly one cycle per store.
- rsp_rdata=0 whenever rsp_valid=0.

Optional Feature:
- Macro: LSU_ERR_EN.
- Defined: the error checks above are active; rsp_err is reported; the access is suppressed on error.
- Undefined:
  - No checking; rsp_err is tied 0.
  - Address bits are truncated: halfword ignores addr[0], word ignores addr[1:0], and upper bits are ignored so accesses wrap modulo 2**DEPTH words.
  - Illegal funct3 is treated as word size.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state enum (3-bit).
  - Byte-lane helper constants.
- One natural sub-module: lsu_lane_align. Purely combinational.
  - Load-side extract/extend from (word, offset, funct3).
  - Store-side merge from (old word, wdata, offset, funct3).
  - Instantiated once for each direction.

Test Plan:
- Memory word 3 = 32'h80FF_7F01; LB @0x0D -> rsp_rdata=32'hFFFF_FF7F? No: offset 1 byte = 7F -> 32'h0000_007F. LB @0x0F -> 32'hFFFF_FF80. LBU @0x0F -> 32'h0000_0080. Each at T+2.
- Same word; LH @0x0E -> 32'hFFFF_80FF; LHU @0x0E -> 32'h0000_80FF; LW @0x0C -> 32'h80FF_7F01.
- SB wdata=32'h1234_56AA @0x0E on word 32'h80FF_7F01 -> one mem_we pulse at T+2; word becomes 32'h80AA_7F01; rsp_valid at T+3.
- SW 32'hDEAD_BEEF @0x10, then LW @0x10 -> 32'hDEAD_BEEF. Exactly one mem_we cycle; rsp_err=0.
- LSU_ERR_EN defined: SH @0x11, LW @0x0402 (DEPTH=8), SW funct3=100 -> rsp_err=1 each, mem_we never asserted, memory unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Assert reset_n=0 during WRITE of a SW -> mem_we=0 immediately, target word unchanged, outputs at reset values.
